// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler: round-robin ALU/LSU arbitration into one registered
// register-file write port, plus a pending-write scoreboard for decode hazards.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            rs1_pending,
    output logic            rs2_pending
);
    localparam int NREG = 1 << AW;

    logic            r_last_lsu;
    logic [NREG-1:0] r_pending;
    logic            w_alu_xfer;
    logic            w_lsu_xfer;
    logic            w_xfer;
    logic            w_write;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    logic [NREG-1:0] w_pending_nxt;

    // Under contention the source that did not win last time goes first.
    assign alu_ready  = alu_valid && (!lsu_valid || r_last_lsu);
    assign lsu_ready  = lsu_valid && (!alu_valid || !r_last_lsu);
    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_lsu_xfer = lsu_valid && lsu_ready;
    assign w_xfer     = w_alu_xfer || w_lsu_xfer;
    assign w_rd       = w_lsu_xfer ? lsu_rd : alu_rd;
    assign w_data     = w_lsu_xfer ? lsu_data : alu_data;
    assign w_write    = w_xfer && (w_rd != '0);

    always_comb begin
        w_pending_nxt = r_pending;
        if (rf_we) begin
            w_pending_nxt[rf_addr] = 1'b0;
        end
        // A fresh issue outranks the retiring write to the same register.
        if (iss_valid && (iss_rd != '0)) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            r_last_lsu <= 1'b1;
            r_pending  <= '0;
        end else begin
            rf_we <= w_write;
            if (w_write) begin
                rf_addr  <= w_rd;
                rf_wdata <= w_data;
            end
            if (w_xfer) begin
                r_last_lsu <= w_lsu_xfer;
            end
            r_pending <= w_pending_nxt;
        end
    end

    // Entry 0 is never set, the explicit guard just keeps x0 reads obviously clean.
    assign rs1_pending = (chk_rs1 != '0) && r_pending[chk_rs1];
    assign rs2_pending = (chk_rs2 != '0) && r_pending[chk_rs2];

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Owns the single write port (A3/WE3/WD3) of the 32-entry register file and shares it between two writeback sources: the ALU/execute stage and the load/store unit. It arbitrates round-robin with valid/ready handshakes and registers the winning write for one cycle before driving the port. A pending-write scoreboard lets decode check whether source registers still have an outstanding writeback.

Parameters:
XLEN, 32, data width of writeback and register file
AW, 5, register address width (2**AW registers; entry 0 is hard-wired zero)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load writeback request
lsu_ready  out  1  load request accepted this cycle
lsu_rd  in  AW  load destination register
lsu_data  in  XLEN  load result
rf_we  out  1  to register file WE3
rf_addr  out  AW  to register file A3
rf_wdata  out  XLEN  to register file WD3
iss_valid  in  1  instruction issued with destination iss_rd
iss_rd  in  AW  destination to mark pending
chk_rs1  in  AW  decode source 1
chk_rs2  in  AW  decode source 2
rs1_pending  out  1  pending[chk_rs1] (combinational)
rs2_pending  out  1  pending[chk_rs2] (combinational)

Behaviour:
- Reset (rst_n=0 at posedge): rf_we=0, rf_addr=0, rf_wdata=0, pending=0, last_grant=LSU, so the ALU wins the first contention. Any in-flight write is dropped. Ready outputs are combinational and depend only on valid and last_grant, so they carry no reset value.
- Arbitration (combinational), same cycle:
  - Only one valid: that source gets ready=1.
  - Both valid: the source not equal to last_grant gets ready=1; the other gets ready=0.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle.
- Handshake: a transfer happens when valid&&ready at a posedge. On a transfer, last_grant updates to the winner. A requester must hold rd/data stable while valid is high and ready is low.
- Write pipeline: the transfer at posedge N drives rf_we=1, rf_addr=rd, rf_wdata=data during cycle N+1. The register file commits at posedge N+1. With no transfer, rf_we=0 next cycle and rf_addr/rf_wdata hold their previous values.
- Throughput: one write per cycle. The port never back-pressures, so the scheduler itself never stalls.
- rd==0: the handshake completes (ready=1, last_grant updates) but rf_we stays 0. x0 is never written and never pending.
- Scoreboard, a pending vector of 2**AW bits:
  - set: iss_valid && iss_rd!=0 sets pending[iss_rd] at the posedge.
  - clear: rf_we=1 clears pending[rf_addr] at the posedge ending that cycle, the same edge the register file commits.
  - Set and clear of the same register at the same edge: set wins, because the newer issue is still outstanding.
  - Set and clear of different registers: both apply.
- rs pending reads: rs1_pending/rs2_pending = pending[chk_rs*]. They remain 1 during the rf_we cycle, since the register file still holds the old value then, and read 0 from the next cycle. chk_rs*=0 always gives 0.
- Misuse: a second issue to an already-pending register keeps the bit set; the first writeback clears it. Decode must avoid this (single-outstanding rule). The bench flags it with an assertion, not RTL.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with alu_valid=1 -> rf_we=0 and all pending=0 throughout. After release, alu_ready=1 and the first write appears one cycle later.
- Single write: alu_valid, rd=5, data=0xDEADBEEF at cycle N -> alu_ready=1 at N; rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF at N+1; rf_we=0 at N+2.
- Contention: both valid for 4 cycles (alu rd=1..4, lsu rd=11..14, each advancing on ready) -> grants alternate ALU, LSU, ALU, LSU; rf_addr sequence is 1, 11, 2, 12.
- x0 discard: lsu_valid, rd=0, data=0x1234 -> lsu_ready=1, rf_we stays 0, rs1_pending for chk_rs1=0 stays 0.
- Scoreboard lifecycle: iss rd=7 at N; alu write rd=7 accepted at N+2 -> rs1_pending(7)=1 from N+1 through N+3 (rf_we cycle), 0 at N+4.
- Simultaneous set/clear: rf_we cycle for rd=9 coincides with iss_valid rd=9 -> pending[9] stays 1 after the edge. A concurrent issue rd=10 while clearing rd=9 -> pending[10]=1, pending[9]=0.
